// File: rtl/game_turn_sched.sv
// Two-player turn scheduler: owns a shared game counter, hands it to p0/p1 in
// fixed slots, scores each game and tracks a match. Optional idle forfeit: SCHED_TIMEOUT_EN.
module game_turn_sched #(
    parameter int unsigned SLOT_LEN   = 8,
    parameter int unsigned NUM_ROUNDS = 3,
    parameter logic [1:0]  LOAD_VAL   = 2'b01,
    parameter int unsigned IDLE_LIM   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       p0_req,
    input  logic       p1_req,
    input  logic [1:0] p0_ctrl,
    input  logic [1:0] p1_ctrl,
    input  logic       game_over,
    input  logic [1:0] game_who,
    output logic       game_init,
    output logic [1:0] game_load,
    output logic [1:0] game_ctrl,
    output logic       p0_gnt,
    output logic       p1_gnt,
    output logic [3:0] p0_wins,
    output logic [3:0] p1_wins,
    output logic [3:0] round,
    output logic       match_done,
    output logic [1:0] match_winner
);
    typedef enum logic [2:0] {IDLE, INIT, SETTLE, PLAY, SCORE, DONE} state_t;

    state_t     state, nstate;
    logic       owner, owner_n, armed;
    logic [7:0] slot, slot_n;
    logic [3:0] p0w_n, p1w_n, round_n;
    logic       own_req, turn_end, credit_p0, credit_p1;
    logic [1:0] own_ctrl, winner_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

    assign own_req   = owner ? p1_req  : p0_req;
    assign own_ctrl  = owner ? p1_ctrl : p0_ctrl;
    // game_who is relative to whoever held the counter when game_over arrived
    assign credit_p0 = (game_who == 2'b10 && !owner) || (game_who == 2'b01 &&  owner);
    assign credit_p1 = (game_who == 2'b10 &&  owner) || (game_who == 2'b01 && !owner);

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] idle, idle_n;
    assign turn_end = (slot == 8'(SLOT_LEN - 1)) || (!own_req && idle == 8'(IDLE_LIM - 1));
    assign idle_n   = (state != PLAY || turn_end || own_req) ? 8'd0 : idle + 8'd1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) idle <= 8'd0;
        else        idle <= idle_n;
`else
    assign turn_end = (slot == 8'(SLOT_LEN - 1));
`endif

    always_comb begin
        nstate  = state;
        owner_n = owner;
        slot_n  = slot;
        p0w_n   = p0_wins;
        p1w_n   = p1_wins;
        round_n = round;
        case (state)
            IDLE, DONE: if (start && armed) begin
                nstate  = INIT;
                p0w_n   = 4'd0;
                p1w_n   = 4'd0;
                round_n = 4'd0;
            end
            INIT: begin
                nstate  = SETTLE;
                owner_n = 1'b0;
                slot_n  = 8'd0;
            end
            SETTLE: nstate = PLAY;
            PLAY: begin
                if (game_over) begin
                    // owner is not toggled here, so a coincident slot expiry scores the old owner
                    nstate  = SCORE;
                    round_n = sat_inc(round);
                    if (credit_p0) p0w_n = sat_inc(p0_wins);
                    if (credit_p1) p1w_n = sat_inc(p1_wins);
                end else if (turn_end) begin
                    owner_n = ~owner;
                    slot_n  = 8'd0;
                end else begin
                    slot_n  = slot + 8'd1;
                end
            end
            SCORE:   nstate = (round == 4'(NUM_ROUNDS)) ? DONE : INIT;
            default: nstate = IDLE;
        endcase
    end

    assign winner_n = (p0w_n > p1w_n) ? 2'b01 : (p1w_n > p0w_n) ? 2'b10 : 2'b11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            armed        <= 1'b0;
            owner        <= 1'b0;
            slot         <= 8'd0;
            game_init    <= 1'b0;
            game_load    <= 2'b00;
            game_ctrl    <= 2'b00;
            p0_gnt       <= 1'b0;
            p1_gnt       <= 1'b0;
            p0_wins      <= 4'd0;
            p1_wins      <= 4'd0;
            round        <= 4'd0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            state        <= nstate;
            armed        <= 1'b1;
            owner        <= owner_n;
            slot         <= slot_n;
            game_init    <= (nstate == INIT);
            game_load    <= (nstate == INIT) ? LOAD_VAL : 2'b00;
            game_ctrl    <= (state == PLAY && nstate == PLAY && own_req) ? own_ctrl : 2'b00;
            p0_gnt       <= (nstate == PLAY) && !owner_n;
            p1_gnt       <= (nstate == PLAY) &&  owner_n;
            p0_wins      <= p0w_n;
            p1_wins      <= p1w_n;
            round        <= round_n;
            match_done   <= (nstate == DONE);
            match_winner <= (nstate == DONE) ? winner_n : 2'b00;
        end
    end
endmodule

// File: tb/tb_game_turn_sched.sv
// Randomized bench for game_turn_sched; expectations come from a per-game timeline model.
module tb_game_turn_sched;
    localparam int SLOT_LEN   = 8;
    localparam int NUM_ROUNDS = 3;
    localparam int IDLE_LIM   = 4;
    localparam logic [1:0] LOAD_VAL = 2'b01;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic p0_req = 1'b0, p1_req = 1'b0, game_over = 1'b0;
    logic [1:0] p0_ctrl = 2'b00, p1_ctrl = 2'b00, game_who = 2'b00;
    logic game_init, p0_gnt, p1_gnt, match_done;
    logic [1:0] game_load, game_ctrl, match_winner;
    logic [3:0] p0_wins, p1_wins, round;
    logic [21:0] all_out;

    int checks = 0, errors = 0;
    int m_p0w = 0, m_p1w = 0, m_round = 0;

    always #5 clk = ~clk;

    assign all_out = {game_init, game_load, game_ctrl, p0_gnt, p1_gnt, p0_wins, p1_wins,
                      round, match_done, match_winner};

    game_turn_sched #(.SLOT_LEN(SLOT_LEN), .NUM_ROUNDS(NUM_ROUNDS), .LOAD_VAL(LOAD_VAL),
                      .IDLE_LIM(IDLE_LIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .p0_req(p0_req), .p1_req(p1_req),
        .p0_ctrl(p0_ctrl), .p1_ctrl(p1_ctrl), .game_over(game_over), .game_who(game_who),
        .game_init(game_init), .game_load(game_load), .game_ctrl(game_ctrl),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_wins(p0_wins), .p1_wins(p1_wins),
        .round(round), .match_done(match_done), .match_winner(match_winner));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // From IDLE or DONE: request a match and land in the first INIT cycle.
    task automatic start_match;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_p0w = 0; m_p1w = 0; m_round = 0;
        checks++;
        if ({p0_wins, p1_wins, round, match_done} !== 13'd0) begin
            errors++;
            $display("FAIL start_clear got %h exp 0", {p0_wins, p1_wins, round, match_done});
        end
    endtask

    // Plays one game starting in its INIT cycle; game_over rises on play cycle L.
    // mode 0: random moves, 1: both req with p0=01 p1=10, 2: nobody requests.
    task automatic play_game(input int L, input logic [1:0] who, input int mode);
        int eo, tc, idl, last_owner;
        logic req_o;
        logic [1:0] exp_ctrl;
        checks++;
        if ({game_init, game_load, p0_gnt, p1_gnt} !== {1'b1, LOAD_VAL, 2'b00}) begin
            errors++;
            $display("FAIL init got %b exp %b", {game_init, game_load, p0_gnt, p1_gnt}, {1'b1, LOAD_VAL, 2'b00});
        end
        tick();
        checks++;
        if ({game_init, game_ctrl, p0_gnt, p1_gnt} !== 5'b0) begin
            errors++;
            $display("FAIL settle got %b exp 00000", {game_init, game_ctrl, p0_gnt, p1_gnt});
        end
        tick();
        eo = 0; tc = 0; idl = 0; exp_ctrl = 2'b00; last_owner = 0;
        for (int k = 0; k <= L; k++) begin
            checks++;
            if ({p0_gnt, p1_gnt} !== (eo != 0 ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL grant k=%0d got %b exp owner p%0d", k, {p0_gnt, p1_gnt}, eo);
            end
            checks++;
            if (game_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL ctrl k=%0d got %b exp %b", k, game_ctrl, exp_ctrl);
            end
            case (mode)
                1: begin p0_req = 1'b1; p1_req = 1'b1; p0_ctrl = 2'b01; p1_ctrl = 2'b10; end
                2: begin p0_req = 1'b0; p1_req = 1'b0; p0_ctrl = 2'($urandom); p1_ctrl = 2'($urandom); end
                default: begin
                    p0_req = 1'($urandom); p1_req = 1'($urandom);
                    p0_ctrl = 2'($urandom); p1_ctrl = 2'($urandom);
                end
            endcase
            start     = 1'($urandom);
            game_over = (k == L);
            game_who  = who;
            req_o     = (eo != 0) ? p1_req : p0_req;
            exp_ctrl  = req_o ? ((eo != 0) ? p1_ctrl : p0_ctrl) : 2'b00;
            last_owner = eo;
`ifdef SCHED_TIMEOUT_EN
            tc++;
            idl = req_o ? 0 : idl + 1;
            if (tc == SLOT_LEN || idl == IDLE_LIM) begin eo = 1 - eo; tc = 0; idl = 0; end
`else
            eo = ((k + 1) / SLOT_LEN) % 2;
`endif
            tick();
        end
        game_over = 1'b0;
        start = 1'b0;
        if (who == 2'b10) begin if (last_owner != 0) m_p1w++; else m_p0w++; end
        if (who == 2'b01) begin if (last_owner != 0) m_p0w++; else m_p1w++; end
        m_round++;
        checks++;
        if ({p0_gnt, p1_gnt, game_init, p0_wins, p1_wins, round} !==
            {3'b000, 4'(m_p0w), 4'(m_p1w), 4'(m_round)}) begin
            errors++;
            $display("FAIL score got gnt=%b init=%b w0=%0d w1=%0d rnd=%0d exp w0=%0d w1=%0d rnd=%0d",
                     {p0_gnt, p1_gnt}, game_init, p0_wins, p1_wins, round, m_p0w, m_p1w, m_round);
        end
        tick();
        if (m_round == NUM_ROUNDS) begin
            checks++;
            if ({match_done, match_winner, p0_gnt, p1_gnt, game_init} !==
                {1'b1, (m_p0w > m_p1w) ? 2'b01 : (m_p1w > m_p0w) ? 2'b10 : 2'b11, 3'b000}) begin
                errors++;
                $display("FAIL done got done=%b win=%b exp win for %0d:%0d", match_done, match_winner, m_p0w, m_p1w);
            end
        end else begin
            checks++;
            if ({game_init, game_load, match_done} !== {1'b1, LOAD_VAL, 1'b0}) begin
                errors++;
                $display("FAIL next_init got %b exp %b", {game_init, game_load, match_done}, {1'b1, LOAD_VAL, 1'b0});
            end
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 22'd0) begin errors++; $display("FAIL reset_outs got %h exp 0", all_out); end
        start = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (game_init !== 1'b0) begin errors++; $display("FAIL first_edge_start got %b exp 0", game_init); end
        tick();
        start = 1'b0;
        m_p0w = 0; m_p1w = 0; m_round = 0;
        checks++;
        if ({game_init, game_load} !== {1'b1, LOAD_VAL}) begin
            errors++;
            $display("FAIL start_accept got %b exp %b", {game_init, game_load}, {1'b1, LOAD_VAL});
        end
    endtask

    // Continues the match opened by test_reset.
    task automatic test_alternate;
        play_game(4 * SLOT_LEN - 1, 2'b11, 1);
    endtask

    task automatic test_score;
        play_game(3, 2'b01, 0);
        play_game(SLOT_LEN + 4, 2'b10, 2);
    endtask

    task automatic test_match;
        start_match();
        play_game(2, 2'b10, 0);
        play_game(SLOT_LEN + 1, 2'b10, 0);
        play_game(SLOT_LEN - 1, 2'b10, 0);
    endtask

    task automatic test_tie_hold;
        start_match();
        play_game(5, 2'b10, 0);
        play_game(4, 2'b01, 0);
        play_game(0, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            p0_req = 1'($urandom); p1_req = 1'($urandom);
            tick();
            checks++;
            if ({match_done, match_winner, p0_wins, p1_wins, round} !==
                {1'b1, 2'b11, 4'(m_p0w), 4'(m_p1w), 4'(m_round)}) begin
                errors++;
                $display("FAIL done_hold got %b", {match_done, match_winner, p0_wins, p1_wins, round});
            end
        end
    endtask

    task automatic test_random;
        for (int m = 0; m < 3; m++) begin
            start_match();
            for (int g = 0; g < NUM_ROUNDS; g++)
                play_game(int'($urandom_range(0, 5 * SLOT_LEN)), 2'($urandom), 0);
        end
    endtask

    task automatic test_reset_midplay;
        start_match();
        tick();
        tick();
        repeat (5) begin p0_req = 1'($urandom); tick(); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 22'd0) begin errors++; $display("FAIL async_reset got %h exp 0", all_out); end
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        checks++;
        if (all_out !== 22'd0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", all_out); end
        tick();
        start = 1'b0;
        m_p0w = 0; m_p1w = 0; m_round = 0;
        play_game(int'($urandom_range(0, 20)), 2'b10, 0);
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_score();
        test_match();
        test_tie_hold();
        test_random();
        test_reset_midplay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
